// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access stage of a single-cycle MIPS datapath.
// Turns the execute-stage effective address and rt data into one
// request/acknowledge bus transfer (LB/LBU/LH/LHU/LW/SB/SH/SW). It holds the
// CPU with `stall` until the transfer completes, and it returns load data
// aligned and extended to the writeback mux.
//
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to abort a request after
// TIMEOUT_CYCLES REQ cycles without bus_ack. The abort pulses bus_error and
// zeroes read_data. If the macro is not defined, REQ waits forever and
// bus_error is tied low.
//
// Bus handshake: bus_req rises together with bus_addr/bus_we/bus_be/bus_wdata.
// All of these hold steady until a rising edge that samples bus_ack high.
// bus_ack is a one-cycle completion strobe that also qualifies bus_rdata.
// bus_ack is ignored while no request is outstanding (IDLE or DONE).
//
// dbg_state_o exposes the FSM state: 0 = IDLE, 1 = REQ, 2 = DONE.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic        stall,
  output logic [31:0] read_data,
  output logic        misaligned,
  output logic        bus_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] read_data_q, read_data_d;
  logic        misaligned_q, misaligned_d;

  logic        req_byte, req_half, req_rw, aligned, access;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] rdata_shifted, load_data;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_error_q, bus_error_d;
`endif

  // Decode the incoming access: alignment, byte enables, lane-replicated store data.
  always_comb begin
    req_byte = (mem_size == 2'b00);
    req_half = (mem_size == 2'b01);
    req_rw   = mem_read | mem_write;
    aligned  = req_byte
             | (req_half & ~alu_result[0])
             | (~req_byte & ~req_half & (alu_result[1:0] == 2'b00));
    access   = req_rw & aligned;
    if (req_byte) begin
      req_be    = 4'b0001 << alu_result[1:0];
      req_wdata = {4{write_data[7:0]}};
    end else if (req_half) begin
      req_be    = 4'b0011 << alu_result[1:0];
      req_wdata = {2{write_data[15:0]}};
    end else begin
      req_be    = 4'b1111;
      req_wdata = write_data;
    end
  end

  // Move the addressed lane down to bit 0, then sign- or zero-extend it for the latched size.
  always_comb begin
    rdata_shifted = bus_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_data = uns_q ? {24'b0, rdata_shifted[7:0]}
                                 : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'b01:   load_data = uns_q ? {16'b0, rdata_shifted[15:0]}
                                 : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_data = rdata_shifted;
    endcase
  end

  // FSM next-state and next-register logic.
  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    read_data_d  = read_data_q;
    misaligned_d = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    cnt_d        = cnt_q;
    bus_error_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write;
          bus_addr_d  = {alu_result[31:2], 2'b00};
          bus_be_d    = req_be;
          bus_wdata_d = req_wdata;
          off_d       = alu_result[1:0];
          size_d      = mem_size;
          uns_d       = mem_unsigned;
          state_d     = ST_REQ;
`ifdef MEM_ACCESS_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end else if (req_rw) begin
          // Bad alignment: flag it and return zero, but never touch the bus.
          misaligned_d = 1'b1;
          read_data_d  = 32'b0;
        end
      end
      ST_REQ: begin
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) read_data_d = load_data;
          state_d = ST_DONE;
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          bus_req_d   = 1'b0;
          bus_error_d = 1'b1;
          read_data_d = 32'b0;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_DONE: begin
        // The instruction retires on this edge; its inputs are still present,
        // so do not re-trigger from them.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'b0;
      bus_be_q     <= 4'b0;
      bus_wdata_q  <= 32'b0;
      off_q        <= 2'b0;
      size_q       <= 2'b0;
      uns_q        <= 1'b0;
      read_data_q  <= 32'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      read_data_q  <= read_data_d;
      misaligned_q <= misaligned_d;
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  // Timeout counter and error pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= '0;
      bus_error_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bus_error_q <= bus_error_d;
    end
  end
  assign bus_error = bus_error_q;
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign bus_error = 1'b0;
`endif

  // Stall covers the launching IDLE cycle and every REQ cycle. While reset is held in IDLE, stall is low.
  assign stall = ((state_q == ST_IDLE) & access & ~reset) | (state_q == ST_REQ);

  assign read_data   = read_data_q;
  assign misaligned  = misaligned_q;
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_be      = bus_be_q;
  assign bus_wdata   = bus_wdata_q;
  assign dbg_state_o = state_q;

endmodule
